// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: register-file write-port initiator.
// Merges single-cycle ALU results with long-latency results buffered in a
// small FIFO, registers the write port, and keeps a per-register pending
// scoreboard for the hazard unit.
// Optional macro WBQ_DRAIN_STALL_EN: when the queue stays full while the ALU
// keeps writing, force a one-cycle ALU stall so the queue head can drain.
module regfile_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_reg,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [4:0]               lsu_reg,
  input  logic [DATA_W-1:0]        lsu_data,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_reg,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic                     rs1_pending,
  output logic                     rs2_pending,
  output logic                     RegWrite,
  output logic [4:0]               Write_register,
  output logic [DATA_W-1:0]        Write_data,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     alu_stall
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [4:0]        q_reg  [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [31:0]       pending;
  logic [31:0]       pending_next;

  logic              push;
  logic              pop;
  logic              sel_alu;
  logic              full;
  logic [4:0]        head_reg;
  logic [DATA_W-1:0] head_data;

  // Arbitration between the ALU path and the queue head
  always_comb begin
    full      = (count == CW'(DEPTH));
    lsu_ready = !full;
    push      = lsu_valid && !full;
    sel_alu   = alu_valid && !alu_stall;
    pop       = !sel_alu && (count != '0);
    head_reg  = q_reg[rd_ptr];
    head_data = q_data[rd_ptr];
  end

  assign queue_count = count;
  assign rs1_pending = pending[rs1];
  assign rs2_pending = pending[rs2];

  // Queue storage: write the tail slot on an accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      q_reg[wr_ptr]  <= lsu_reg;
      q_data[wr_ptr] <= lsu_data;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered write port; address/data hold when nothing is selected
  always_ff @(posedge clk) begin
    if (!reset) begin
      RegWrite       <= 1'b0;
      Write_register <= '0;
      Write_data     <= '0;
    end else if (sel_alu) begin
      RegWrite       <= (alu_reg != 5'd0);
      Write_register <= alu_reg;
      Write_data     <= alu_data;
    end else if (pop) begin
      RegWrite       <= (head_reg != 5'd0);
      Write_register <= head_reg;
      Write_data     <= head_data;
    end else begin
      RegWrite       <= 1'b0;
    end
  end

  // Pending scoreboard next state: clear on pop, then set on issue so set wins
  always_comb begin
    pending_next = pending;
    if (pop) pending_next[head_reg] = 1'b0;
    if (issue_valid) pending_next[issue_reg] = 1'b1;
    pending_next[0] = 1'b0;
  end

  // Pending scoreboard register
  always_ff @(posedge clk) begin
    if (!reset) pending <= '0;
    else        pending <= pending_next;
  end

`ifdef WBQ_DRAIN_STALL_EN
  logic [1:0] drain_cnt;

  // Count consecutive full+ALU cycles; on reaching 2 stall the ALU for one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      drain_cnt <= '0;
      alu_stall <= 1'b0;
    end else if (alu_stall) begin
      drain_cnt <= '0;
      alu_stall <= 1'b0;
    end else if (full && alu_valid) begin
      drain_cnt <= drain_cnt + 1'b1;
      alu_stall <= (drain_cnt == 2'd1);
    end else begin
      drain_cnt <= '0;
      alu_stall <= 1'b0;
    end
  end
`else
  // Without the drain feature the ALU always has priority
  always_comb alu_stall = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Testbench for regfile_writeback_queue: behavioural model plus a scoreboard
// of expected register-file writes.
`timescale 1ns/1ps
module tb_regfile_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid;
  logic [4:0]        alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [4:0]        lsu_reg;
  logic [DATA_W-1:0] lsu_data;
  logic              issue_valid;
  logic [4:0]        issue_reg;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic              rs1_pending;
  logic              rs2_pending;
  logic              RegWrite;
  logic [4:0]        Write_register;
  logic [DATA_W-1:0] Write_data;
  logic [$clog2(DEPTH):0] queue_count;
  logic              alu_stall;

  regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_reg(lsu_reg), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .rs1(rs1), .rs2(rs2), .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
    .queue_count(queue_count), .alu_stall(alu_stall)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model state
  logic [4+DATA_W:0] mq[$];   // {reg, data} entries awaiting writeback
  logic [4+DATA_W:0] sb[$];   // expected register-file writes
  logic [31:0]       mpend;
  logic              mstall;
  int unsigned       mcnt;
  logic              mwe;
  logic              stall_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_reg = '0; lsu_data = '0;
    issue_valid = 1'b0; issue_reg = '0;
  endtask

  // One clock cycle: check combinational outputs, advance model, check write port
  task automatic step();
    logic        psh, pp, sel, full;
    logic [4+DATA_W:0] hd;
    logic [4+DATA_W:0] ex;
    #1;
    check("queue_count", 64'(queue_count), 64'(mq.size()));
    check("lsu_ready", 64'(lsu_ready), 64'(mq.size() < DEPTH));
    check("rs1_pending", 64'(rs1_pending), 64'(mpend[rs1]));
    check("rs2_pending", 64'(rs2_pending), 64'(mpend[rs2]));
    check("alu_stall", 64'(alu_stall), 64'(mstall));
    if (alu_stall) stall_seen = 1'b1;
    @(posedge clk);
    #1;
    if (!reset) begin
      mq.delete(); sb.delete();
      mpend = '0; mstall = 1'b0; mcnt = 0; mwe = 1'b0;
      check("rst_regwrite", 64'(RegWrite), 64'd0);
      check("rst_wreg", 64'(Write_register), 64'd0);
      check("rst_wdata", 64'(Write_data), 64'd0);
      return;
    end
    full = (mq.size() == DEPTH);
    psh  = lsu_valid && !full;
    sel  = alu_valid && !mstall;
    pp   = !sel && (mq.size() != 0);
    mwe  = 1'b0;
    if (sel) begin
      mwe = (alu_reg != 0);
      if (mwe) sb.push_back({alu_reg, alu_data});
    end else if (pp) begin
      hd  = mq.pop_front();
      mwe = (hd[4+DATA_W:DATA_W] != 0);
      if (mwe) sb.push_back(hd);
      mpend[hd[4+DATA_W:DATA_W]] = 1'b0;
    end
    if (psh) mq.push_back({lsu_reg, lsu_data});
    if (issue_valid && issue_reg != 0) mpend[issue_reg] = 1'b1;
`ifdef WBQ_DRAIN_STALL_EN
    if (mstall) begin
      mstall = 1'b0; mcnt = 0;
    end else if (full && alu_valid) begin
      mcnt++;
      if (mcnt == 2) mstall = 1'b1;
    end else begin
      mcnt = 0;
    end
`endif
    check("regwrite", 64'(RegWrite), 64'(mwe));
    if (RegWrite) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_write", 64'(Write_register), 64'hFFFF);
      end else begin
        ex = sb.pop_front();
        check("wreg", 64'(Write_register), 64'(ex[4+DATA_W:DATA_W]));
        check("wdata", 64'(Write_data), 64'(ex[DATA_W-1:0]));
      end
    end
  endtask

  initial begin
    mpend = '0; mstall = 1'b0; mcnt = 0; mwe = 1'b0; stall_seen = 1'b0;
    idle(); rs1 = '0; rs2 = '0;
    reset = 1'b0;
    @(posedge clk); #1;
    step(); step();
    reset = 1'b1;
    step();
    check("reset_regwrite", 64'(RegWrite), 64'd0);
    check("reset_count", 64'(queue_count), 64'd0);
    check("reset_ready", 64'(lsu_ready), 64'd1);
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); #1;
      check("reset_rs1_pending", 64'(rs1_pending), 64'd0);
    end
    rs1 = '0;

    // Single ALU write
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h1234;
    step();
    check("alu_we", 64'(RegWrite), 64'd1);
    check("alu_wreg", 64'(Write_register), 64'd5);
    check("alu_wdata", 64'(Write_data), 64'h1234);
    idle();
    step();
    check("alu_we_after", 64'(RegWrite), 64'd0);

    // Long-latency issue, pending, then push and pop
    rs1 = 5'd8;
    issue_valid = 1'b1; issue_reg = 5'd8;
    step();
    idle();
    check("pend8_after_issue", 64'(rs1_pending), 64'd1);
    step(); step();
    lsu_valid = 1'b1; lsu_reg = 5'd8; lsu_data = 32'hCAFE;
    step();
    idle();
    check("pend8_before_pop", 64'(rs1_pending), 64'd1);
    step();
    check("ll_we", 64'(RegWrite), 64'd1);
    check("ll_wreg", 64'(Write_register), 64'd8);
    check("ll_wdata", 64'(Write_data), 64'hCAFE);
    check("pend8_after_pop", 64'(rs1_pending), 64'd0);

    // Fill with ALU busy; 5th offer refused
    alu_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      alu_reg = 5'd1; alu_data = 32'(i);
      lsu_valid = 1'b1; lsu_reg = 5'(10 + i); lsu_data = 32'hA00 + 32'(i);
      step();
    end
`ifndef WBQ_DRAIN_STALL_EN
    check("full_ready", 64'(lsu_ready), 64'd0);
    check("full_count", 64'(queue_count), 64'd4);
`endif
    idle();
    for (int i = 0; i < 6; i++) step();
    check("drained_count", 64'(queue_count), 64'd0);

    // reg-0 entry then reg 3; issue 3 on the cycle reg 3 pops
    rs2 = 5'd3;
    lsu_valid = 1'b1; lsu_reg = 5'd0; lsu_data = 32'h55;
    step();
    lsu_reg = 5'd3; lsu_data = 32'h77;
    step();
    idle();
    issue_valid = 1'b1; issue_reg = 5'd3;
    step();
    idle();
    check("r3_we", 64'(RegWrite), 64'd1);
    check("r3_wdata", 64'(Write_data), 64'h77);
    check("pend3_set_wins", 64'(rs2_pending), 64'd1);

    // Full queue with ALU held busy
    stall_seen = 1'b0;
    alu_valid = 1'b1; alu_reg = 5'd2;
    for (int i = 0; i < 10; i++) begin
      alu_data = 32'h100 + 32'(i);
      lsu_valid = 1'b1; lsu_reg = 5'(16 + i); lsu_data = 32'hB00 + 32'(i);
      step();
    end
`ifdef WBQ_DRAIN_STALL_EN
    check("drain_stall_seen", 64'(stall_seen), 64'd1);
`else
    check("no_stall", 64'(stall_seen), 64'd0);
`endif

    // Reset mid-fill
    lsu_valid = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    idle();
    step();
    check("midrst_we", 64'(RegWrite), 64'd0);
    check("midrst_count", 64'(queue_count), 64'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      alu_valid   = ($urandom_range(0, 99) < 45);
      alu_reg     = 5'($urandom_range(0, 7));
      alu_data    = $urandom;
      lsu_valid   = ($urandom_range(0, 99) < 50);
      lsu_reg     = 5'($urandom_range(0, 7));
      lsu_data    = $urandom;
      issue_valid = ($urandom_range(0, 99) < 30);
      issue_reg   = 5'($urandom_range(0, 7));
      rs1         = 5'($urandom_range(0, 7));
      rs2         = 5'($urandom_range(0, 7));
      step();
    end
    idle();
    for (int i = 0; i < 20 && mq.size() != 0; i++) step();
    step();
    check("final_count", 64'(queue_count), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
